ks_nibble_sequencer: RTL and testbench

//  Upstream operand sequencer for the registered 4-bit Kogge-Stone adder top.
//  - Accepts one WIDTH-bit add request over a valid/ready handshake.
//  - Slices the operands into 4-bit nibbles, LSB first, and drives each nibble into the adder.
//  - Chains the adder's carry-out into the next nibble's carry-in.
//  - Collects the sum nibbles and returns the full WIDTH-bit result over a second valid/ready handshake.

---
 rtl/ks_pkg.sv | 8 +
 rtl/ks_lat_counter.sv | 15 +
 rtl/ks_nibble_sequencer.sv | 94 +++++++++
 tb/tb_ks_nibble_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// ks_pkg: shared types, constants and helpers for the Kogge-Stone nibble sequencer
package ks_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} ks_seq_state_t;
  function automatic int nib_cnt(input int width);
    return width / NIB_W;
  endfunction
endpackage

// File: rtl/ks_lat_counter.sv
// ks_lat_counter: WAIT-state cycle counter; hit flags count == LAT. Ports: clk, rst (sync active-low), run (count, else clear), hit.
module ks_lat_counter #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic hit
);
  localparam int CW = $clog2(LAT + 2);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!rst || !run) ? '0 : cnt + 1'b1;
  assign hit = cnt == CW'(LAT);
endmodule

// File: rtl/ks_nibble_sequencer.sv
// ks_nibble_sequencer: slices a WIDTH-bit add into 4-bit adds through an external registered adder.
// Ports: clk, rst (sync active-low); op_valid/op_ready/op_a/op_b/op_cin request;
// res_valid/res_ready/res_sum/res_cout result; add_a/add_b/add_cin to adder, add_sum/add_cout from adder.
// Optional macro KS_SEQ_OVERFLOW_EN adds res_ovf (two's-complement overflow, valid with res_valid).
module ks_nibble_sequencer
  import ks_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDER_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
`ifdef KS_SEQ_OVERFLOW_EN
  output logic             res_ovf,
`endif
  output logic [NIB_W-1:0] add_a,
  output logic [NIB_W-1:0] add_b,
  output logic             add_cin,
  input  logic [NIB_W-1:0] add_sum,
  input  logic             add_cout
);
  localparam int NIBS = nib_cnt(WIDTH);
  localparam int KW   = $clog2(NIBS);
  ks_seq_state_t state, nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [KW-1:0]    k;
  logic             carry_q, hit, last;
  assign last = k == KW'(NIBS - 1);
  ks_lat_counter #(.LAT(ADDER_LAT)) u_cnt (
    .clk(clk),
    .rst(rst),
    .run(state == WAIT),
    .hit(hit)
  );
  always_ff @(posedge clk)
    state <= !rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = op_valid ? ISSUE : IDLE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = hit ? (last ? DONE : ISSUE) : WAIT;
      DONE:    nxt = res_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    op_ready  = state == IDLE;
    res_valid = state == DONE;
  end
  // carry_q holds op_cin before nibble 0, then each nibble's carry-out; after the last nibble it is the result carry
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      k       <= '0;
      carry_q <= 1'b0;
      res_sum <= '0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else begin
      if (state == IDLE && op_valid) begin
        a_q     <= op_a;
        b_q     <= op_b;
        carry_q <= op_cin;
        k       <= '0;
      end
      if (state == ISSUE) begin
        add_a   <= a_q[k*NIB_W +: NIB_W];
        add_b   <= b_q[k*NIB_W +: NIB_W];
        add_cin <= carry_q;
      end
      if (state == WAIT && hit) begin
        res_sum[k*NIB_W +: NIB_W] <= add_sum;
        carry_q                   <= add_cout;
        k                         <= last ? '0 : k + 1'b1;
      end
    end
  end
  assign res_cout = carry_q;
`ifdef KS_SEQ_OVERFLOW_EN
  assign res_ovf = res_valid && (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_sum[WIDTH-1] != a_q[WIDTH-1]);
`endif
endmodule

// File: tb/tb_ks_nibble_sequencer.sv
// tb_ks_nibble_sequencer: directed self-checking bench with a registered 4-bit adder model attached
module tb_ks_nibble_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0, op_ready, op_cin = 1'b0;
  logic [15:0] op_a = '0, op_b = '0, res_sum;
  logic        res_valid, res_ready = 1'b0, res_cout;
  logic [3:0]  add_a, add_b, add_sum, ai, bi;
  logic        add_cin, add_cout, ci;
  int          n_chk = 0, n_pass = 0;
`ifdef KS_SEQ_OVERFLOW_EN
  logic        res_ovf;
`endif
  always #5 clk = ~clk;
  ks_nibble_sequencer #(.WIDTH(16), .ADDER_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
`ifdef KS_SEQ_OVERFLOW_EN
    .res_ovf(res_ovf),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      ai <= '0;
      bi <= '0;
      ci <= 1'b0;
      {add_cout, add_sum} <= '0;
    end else begin
      ai <= add_a;
      bi <= add_b;
      ci <= add_cin;
      {add_cout, add_sum} <= {1'b0, ai} + {1'b0, bi} + {4'b0, ci};
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin);
    op_a = a;
    op_b = b;
    op_cin = cin;
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask
  task automatic wait_res(input string tag, input logic [15:0] s, input logic c, input logic ovf);
    int n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 16);
    check({tag, "_sum"}, res_sum, s);
    check({tag, "_cout"}, res_cout, c);
    check({tag, "_rdy"}, op_ready, 0);
`ifdef KS_SEQ_OVERFLOW_EN
    check({tag, "_ovf"}, res_ovf, ovf);
`else
    if (ovf) check({tag, "_ovf_tag"}, 0, 0);
`endif
  endtask
  task automatic retire(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_idle"}, {op_ready, res_valid}, 2'b10);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_rdy"}, op_ready, 1);
    check({tag, "_outs"}, {res_valid, res_cout, add_cin, add_a, add_b}, 0);
    check({tag, "_sum"}, res_sum, 0);
  endtask
  initial begin
    tick();
    tick();
    check_reset("rst0");
    rst = 1'b1;
    tick();
    send(16'h1234, 16'h4321, 1'b0);
    wait_res("t1", 16'h5555, 1'b0, 1'b0);
    retire("t1");
    send(16'hFFFF, 16'h0001, 1'b0);
    wait_res("t2", 16'h0000, 1'b1, 1'b0);
    retire("t2");
    send(16'hFFFF, 16'h0000, 1'b1);
    wait_res("t3", 16'h0000, 1'b1, 1'b0);
    retire("t3");
    send(16'h8000, 16'h8000, 1'b0);
    wait_res("t4", 16'h0000, 1'b1, 1'b1);
    retire("t4");
    send(16'hA5A5, 16'h5A5A, 1'b0);
    wait_res("t5", 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_sum", res_sum, 16'hFFFF);
      check("hold_flags", {res_valid, res_cout, op_ready}, 3'b100);
    end
    op_a = 16'h0100;
    op_b = 16'h0200;
    op_cin = 1'b0;
    op_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("b2b_idle", {op_ready, res_valid}, 2'b10);
    tick();
    op_valid = 1'b0;
    check("b2b_accept", op_ready, 0);
    wait_res("b2b", 16'h0300, 1'b0, 1'b0);
    retire("b2b");
    send(16'h1111, 16'h2222, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b0;
    tick();
    check_reset("rst_mid");
    rst = 1'b1;
    send(16'h0003, 16'h0004, 1'b0);
    wait_res("t6", 16'h0007, 1'b0, 1'b0);
    retire("t6");
`ifdef KS_SEQ_OVERFLOW_EN
    send(16'h7FFF, 16'h0001, 1'b0);
    wait_res("ov1", 16'h8000, 1'b0, 1'b1);
    retire("ov1");
    send(16'h0001, 16'h0001, 1'b0);
    wait_res("ov2", 16'h0002, 1'b0, 1'b0);
    retire("ov2");
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
